// File: rtl/pipe_stage_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_buf_pkg
// Description : Shared types and helpers for the generic pipeline stage
//               register: occupancy state encoding, default widths, and
//               the upstream-room predicate for both buffer depths.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_stage_buf_pkg;

    // Occupancy of the stage: nothing held, main entry only, main + skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_e;

    localparam int unsigned c_DEF_DATA_W = 64;
    localparam int unsigned c_DEF_CNT_W  = 64;

    // Whether the stage can take another beat, ignoring hold/flush masking.
    // With the skid entry the answer depends on occupancy only, which keeps
    // out_ready off the in_ready path. Without it, a full single entry can
    // only take a beat when the current one leaves in the same cycle.
    function automatic logic has_room(input stage_state_e st,
                                      input logic         out_ready,
                                      input bit           skid_en);
        if (skid_en) begin
            return (st != TWO);
        end
        return (st == EMPTY) || out_ready;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_buf_if
// Description : Valid/ready handshake bundle between two pipeline stages.
//               The upstream side offers in_*, the downstream side consumes
//               out_*.
//   in_valid   upstream payload valid
//   in_ready   stage accepts payload this cycle
//   in_data    upstream payload (DATA_W)
//   out_valid  payload presented downstream
//   out_ready  downstream accepts
//   out_data   payload presented downstream (DATA_W)
//   modport master : environment side (drives in_*, out_ready)
//   modport slave  : stage side (drives in_ready, out_*)
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_buf_if #(
    parameter int DATA_W = 64
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface
`default_nettype wire

// File: rtl/pipe_stage_buf_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with dominant synchronous clear.
//               Holds at all-ones once reached until cleared.
//   clk    in   clock
//   reset  in   asynchronous active-low reset
//   inc    in   count up by one this cycle (ignored when saturated)
//   clr    in   clear to zero this cycle (wins over inc)
//   count  out  current count (CNT_W)
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;
    logic             w_sat;

    assign w_sat = &r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && !w_sat) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_buf
// Description : Generic inter-stage pipeline register with valid/ready
//               handshake, optional 2-entry skid buffer, external hold,
//               deferred flush and a saturating stall-cycle counter.
//   clk      in   clock
//   reset    in   asynchronous active-low reset
//   hold     in   freeze the stage (memory handshake stall)
//   flush    in   discard stage contents (jump / CSR redirect)
//   bus      if   pipe_stage_buf_if.slave handshake bundle
//   counter  out  consecutive stalled cycles (CNT_W, saturating)
// Parameters:
//   DATA_W   payload width
//   CNT_W    stall counter width
//   SKID_EN  1 = main + skid entry, 0 = single entry
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int CNT_W   = 64,
    parameter bit SKID_EN = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                hold,
    input  logic                flush,
    pipe_stage_buf_if.slave     bus,
    output logic [CNT_W-1:0]    counter
);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    stage_state_e      r_state;
    stage_state_e      w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] w_main_nxt;
    logic [DATA_W-1:0] r_skid;
    logic [DATA_W-1:0] w_skid_nxt;
    logic              r_flush_pend;
    logic              w_flush_pend_nxt;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_fl;
    logic w_room;
    logic w_in_ready;
    logic w_out_valid;
    logic w_enq;
    logic w_deq;
    logic w_cnt_inc;
    logic w_cnt_clr;

    // A flush seen while held is parked in r_flush_pend and takes effect
    // in the first unheld cycle, so a redirect is never lost to a stall.
    assign w_fl = !hold && (flush || r_flush_pend);

    assign w_room      = has_room(r_state, bus.out_ready, SKID_EN);
    assign w_out_valid = (r_state != EMPTY) && !hold && !w_fl;
    // Gated by reset so upstream sees no room while the stage is in reset.
    assign w_in_ready  = reset && w_room && !hold && !w_fl;

    assign w_enq = bus.in_valid && w_in_ready;
    assign w_deq = w_out_valid && bus.out_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_main;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= EMPTY;
            r_main       <= '0;
            r_skid       <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_main       <= w_main_nxt;
            r_skid       <= w_skid_nxt;
            r_flush_pend <= w_flush_pend_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_main_nxt       = r_main;
        w_skid_nxt       = r_skid;
        w_flush_pend_nxt = r_flush_pend;

        if (hold) begin
            // Frozen: contents untouched, only remember a flush request.
            if (flush) begin
                w_flush_pend_nxt = 1'b1;
            end
        end else if (w_fl) begin
            w_state_nxt      = EMPTY;
            w_main_nxt       = '0;
            w_skid_nxt       = '0;
            w_flush_pend_nxt = 1'b0;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (w_enq) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = bus.in_data;
                    end
                end
                ONE: begin
                    if (w_enq && w_deq) begin
                        w_main_nxt = bus.in_data;
                    end else if (w_enq) begin
                        // Only reachable with the skid entry: without it,
                        // in_ready in ONE implies out_ready, hence a deq.
                        w_state_nxt = TWO;
                        w_skid_nxt  = bus.in_data;
                    end else if (w_deq) begin
                        w_state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a dequeue can happen;
                    // the older skid beat moves up to keep FIFO order.
                    if (w_deq) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = r_skid;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stall counter
    // ------------------------------------------------------------------
    // Counts cycles in which the stage is held or has a beat that the
    // downstream refuses. Any other cycle ends the stall run and clears it.
    assign w_cnt_inc = hold || ((r_state != EMPTY) && !bus.out_ready);
    assign w_cnt_clr = w_deq || w_fl || !w_cnt_inc;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_cnt_inc),
        .clr   (w_cnt_clr),
        .count (counter)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_buf
// Description : Self-checking bench for pipe_stage_buf. Accepted beats are
//               queued as expected output; a monitor pops and compares every
//               downstream transfer. Directed checks cover reset, skid
//               stall, hold, deferred flush, counter saturation (CNT_W=3)
//               and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_buf;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        hold  = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] counter;

    logic        hold2  = 1'b0;
    logic        flush2 = 1'b0;
    logic [2:0]  counter2;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb_q[$];
    logic [7:0] exp_d;

    pipe_stage_buf_if #(.DATA_W(8)) bus  ();
    pipe_stage_buf_if #(.DATA_W(8)) bus2 ();

    pipe_stage_buf #(
        .DATA_W  (8),
        .CNT_W   (16),
        .SKID_EN (1'b1)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .hold    (hold),
        .flush   (flush),
        .bus     (bus),
        .counter (counter)
    );

    pipe_stage_buf #(
        .DATA_W  (8),
        .CNT_W   (3),
        .SKID_EN (1'b1)
    ) u_sat (
        .clk     (clk),
        .reset   (reset),
        .hold    (hold2),
        .flush   (flush2),
        .bus     (bus2),
        .counter (counter2)
    );

    always #5 clk = ~clk;

    // Expected-response producer: every accepted upstream beat.
    always @(negedge clk) begin
        if (reset && bus.in_valid && bus.in_ready) begin
            sb_q.push_back(bus.in_data);
        end
    end

    // Output monitor: every downstream transfer must match the queue head.
    always @(negedge clk) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL out_beat: got %0h, required no beat", bus.out_data);
            end else begin
                exp_d = sb_q.pop_front();
                if (bus.out_data !== exp_d) begin
                    bad++;
                    $display("FAIL out_beat: got %0h, required %0h", bus.out_data, exp_d);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [7:0] d, input logic ordy,
                          input logic h, input logic f);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        hold          = h;
        flush         = f;
        #1;
    endtask

    task automatic set2(input logic v, input logic [7:0] d, input logic ordy);
        bus2.in_valid  = v;
        bus2.in_data   = d;
        bus2.out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_data   = '0;
        bus2.out_ready = 1'b0;

        // ---------------- reset ----------------
        #2;
        check("rst_in_ready",  bus.in_ready,  0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data",  bus.out_data,  0);
        check("rst_counter",   counter,       0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("rel_in_ready", bus.in_ready, 1);
        tick();

        // ---------------- single beat latency ----------------
        set_in(1, 8'hA5, 1, 0, 0);
        check("t1_counter0", counter, 0);
        tick();
        set_in(0, 8'h00, 1, 0, 0);
        check("t1_out_valid", bus.out_valid, 1);
        check("t1_out_data",  bus.out_data,  8'hA5);
        check("t1_counter1",  counter,       0);
        tick();
        set_in(0, 8'h00, 1, 0, 0);
        check("t1_empty", bus.out_valid, 0);
        tick();

        // ---------------- skid stall ----------------
        set_in(1, 8'd1, 1, 0, 0);
        tick();
        set_in(1, 8'd2, 1, 0, 0);
        check("t2_data1", bus.out_data, 1);
        tick();
        set_in(1, 8'd3, 0, 0, 0);
        check("t2_rdy_one", bus.in_ready, 1);
        check("t2_cnt0",    counter,      0);
        tick();
        set_in(1, 8'd4, 0, 0, 0);
        check("t2_rdy_two_a", bus.in_ready, 0);
        check("t2_cnt1",      counter,      1);
        tick();
        set_in(1, 8'd4, 0, 0, 0);
        check("t2_rdy_two_b", bus.in_ready, 0);
        check("t2_cnt2",      counter,      2);
        tick();
        set_in(1, 8'd4, 1, 0, 0);
        check("t2_rdy_two_c", bus.in_ready, 0);
        check("t2_cnt3",      counter,      3);
        check("t2_data2",     bus.out_data, 2);
        tick();
        set_in(1, 8'd4, 1, 0, 0);
        check("t2_cnt_clr", counter,      0);
        check("t2_rdy_one2", bus.in_ready, 1);
        check("t2_data3",   bus.out_data, 3);
        tick();
        set_in(0, 8'd0, 1, 0, 0);
        check("t2_data4", bus.out_data, 4);
        tick();
        set_in(0, 8'd0, 1, 0, 0);
        check("t2_drained", bus.out_valid, 0);
        check("t2_queue",   sb_q.size(),   0);
        tick();

        // ---------------- hold ----------------
        set_in(1, 8'h07, 1, 0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            set_in(1, 8'h99, 1, 1, 0);
            check("t3_hold_valid", bus.out_valid, 0);
            check("t3_hold_ready", bus.in_ready,  0);
            check("t3_hold_cnt",   counter,       i);
            check("t3_hold_data",  bus.out_data,  8'h07);
            tick();
        end
        set_in(0, 8'h00, 1, 0, 0);
        check("t3_cnt5",   counter,       5);
        check("t3_valid",  bus.out_valid, 1);
        check("t3_data",   bus.out_data,  8'h07);
        tick();
        set_in(0, 8'h00, 1, 0, 0);
        check("t3_cnt_clr", counter,       0);
        check("t3_empty",   bus.out_valid, 0);
        tick();

        // ---------------- flush during hold ----------------
        set_in(1, 8'h3C, 0, 0, 0);
        tick();
        set_in(0, 8'h00, 0, 1, 1);
        check("t4_hold_valid", bus.out_valid, 0);
        check("t4_hold_ready", bus.in_ready,  0);
        tick();
        set_in(0, 8'h00, 0, 1, 0);
        check("t4_hold_cnt",  counter,      1);
        check("t4_hold_data", bus.out_data, 8'h3C);
        tick();
        set_in(1, 8'h55, 1, 0, 0);
        check("t4_fl_valid", bus.out_valid, 0);
        check("t4_fl_ready", bus.in_ready,  0);
        check("t4_fl_cnt",   counter,       2);
        sb_q.delete();
        tick();
        set_in(0, 8'h00, 1, 0, 0);
        check("t4_post_valid", bus.out_valid, 0);
        check("t4_post_data",  bus.out_data,  0);
        check("t4_post_cnt",   counter,       0);
        check("t4_post_ready", bus.in_ready,  1);
        tick();

        // ---------------- counter saturation (CNT_W=3) ----------------
        set2(1, 8'h42, 0);
        tick();
        for (int i = 1; i <= 10; i++) begin
            set2(0, 8'h00, 0);
            check("t5_cnt", counter2, (i - 1 > 7) ? 7 : i - 1);
            tick();
        end
        set2(0, 8'h00, 1);
        check("t5_cnt_sat", counter2,       7);
        check("t5_valid",   bus2.out_valid, 1);
        check("t5_data",    bus2.out_data,  8'h42);
        tick();
        set2(0, 8'h00, 0);
        check("t5_cnt_clr", counter2,       0);
        check("t5_empty",   bus2.out_valid, 0);
        tick();

        // ---------------- async reset in TWO ----------------
        set_in(1, 8'h11, 0, 0, 0);
        tick();
        set_in(1, 8'h22, 0, 0, 0);
        tick();
        set_in(0, 8'h00, 0, 0, 0);
        check("t6_two_ready", bus.in_ready,  0);
        check("t6_two_valid", bus.out_valid, 1);
        check("t6_two_cnt",   counter,       1);
        #1 reset = 1'b0;
        #1;
        check("t6_ar_valid", bus.out_valid, 0);
        check("t6_ar_data",  bus.out_data,  0);
        check("t6_ar_cnt",   counter,       0);
        check("t6_ar_ready", bus.in_ready,  0);
        sb_q.delete();
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("t6_rel_ready", bus.in_ready,  1);
        check("t6_rel_valid", bus.out_valid, 0);
        tick();
        set_in(1, 8'h5A, 1, 0, 0);
        tick();
        set_in(0, 8'h00, 1, 0, 0);
        check("t6_recover", bus.out_data, 8'h5A);
        tick();
        set_in(0, 8'h00, 1, 0, 0);
        check("t6_queue", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
